// File: rtl/prbs_gen_chk.sv
// PRBS generator (Fibonacci LFSR, seedable, self-recovering from all-zero) and matching
// serial checker that hunts for sequence alignment, tracks lock and counts bit errors.
module prbs_gen_chk #(
    parameter int               ORDER       = 16,
    parameter logic [ORDER-1:0] TAP_MASK    = 16'hD008,
    parameter logic [ORDER-1:0] SEED        = '1,
    parameter int               ERR_W       = 16,
    parameter int               LOCK_THRESH = 8,
    parameter int               LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             seed_load,
    input  logic [ORDER-1:0] seed_val,
    output logic [ORDER-1:0] gen_state,
    output logic             gen_bit,
    input  logic             chk_valid,
    input  logic             chk_bit,
    input  logic             err_clr,
    output logic             chk_locked,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       chk_state
);

    localparam int BIT_W   = $clog2(ORDER + 1);
    localparam int RUN_MAX = (LOCK_THRESH > LOSS_THRESH) ? LOCK_THRESH : LOSS_THRESH;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(ORDER - 1);
    localparam logic [RUN_W-1:0] LOCK_LAST = RUN_W'(LOCK_THRESH - 1);
    localparam logic [RUN_W-1:0] LOSS_LAST = RUN_W'(LOSS_THRESH - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    function automatic logic fb(input logic [ORDER-1:0] s);
        return ^(s & TAP_MASK);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            gen_state <= SEED;
        end else if (seed_load) begin
            gen_state <= (seed_val == '0) ? SEED : seed_val;
        end else if (shift_en) begin
            // An all-zero register would stay stuck forever; reseed instead of shifting.
            gen_state <= (gen_state == '0) ? SEED : {gen_state[ORDER-2:0], fb(gen_state)};
        end
    end

    assign gen_bit = gen_state[ORDER-1];

    chk_state_t       state;
    logic [ORDER-1:0] chk_reg;
    logic [BIT_W-1:0] bit_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic             pred;
    logic             miss;
    logic             count_err;

    assign pred      = fb(chk_reg);
    assign miss      = (chk_bit != pred);
    assign count_err = chk_valid && (state == LOCKED) && miss;
    assign chk_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            chk_reg    <= '0;
            bit_cnt    <= '0;
            run_cnt    <= '0;
            chk_locked <= 1'b0;
            err_count  <= '0;
        end else begin
            if (chk_valid) begin
                case (state)
                    HUNT: begin
                        chk_reg <= {chk_reg[ORDER-2:0], chk_bit};
                        if (bit_cnt == LAST_BIT) begin
                            state   <= VERIFY;
                            bit_cnt <= '0;
                            run_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    VERIFY: begin
                        if (!miss) begin
                            chk_reg <= {chk_reg[ORDER-2:0], pred};
                            if (run_cnt == LOCK_LAST) begin
                                state      <= LOCKED;
                                chk_locked <= 1'b1;
                                run_cnt    <= '0;
                            end else begin
                                run_cnt <= run_cnt + 1'b1;
                            end
                        end else begin
                            // The offending bit starts the next fill.
                            state   <= HUNT;
                            chk_reg <= {chk_reg[ORDER-2:0], chk_bit};
                            bit_cnt <= BIT_W'(1);
                            run_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-running predictor: a channel error never corrupts chk_reg.
                        chk_reg <= {chk_reg[ORDER-2:0], pred};
                        if (miss) begin
                            if (run_cnt == LOSS_LAST) begin
                                state      <= HUNT;
                                chk_locked <= 1'b0;
                                bit_cnt    <= '0;
                                run_cnt    <= '0;
                            end else begin
                                run_cnt <= run_cnt + 1'b1;
                            end
                        end else begin
                            run_cnt <= '0;
                        end
                    end
                    default: begin
                        state      <= HUNT;
                        chk_locked <= 1'b0;
                        bit_cnt    <= '0;
                        run_cnt    <= '0;
                    end
                endcase
            end

            if (err_clr) begin
                err_count <= count_err ? ERR_W'(1) : '0;
            end else if (count_err && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Bench for prbs_gen_chk: generator sequence, seeding, loopback lock, error counting,
// saturation (narrow counter instance sharing the same stimulus) and mid-run reset.
module tb_prbs_gen_chk;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        shift_en = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_val = '0;
    logic        chk_valid = 1'b0;
    logic        chk_bit = 1'b0;
    logic        err_clr = 1'b0;

    logic [15:0] gen_state, gen_state_s;
    logic        gen_bit, gen_bit_s;
    logic        chk_locked, chk_locked_s;
    logic [15:0] err_count;
    logic [3:0]  err_count_s;
    logic [1:0]  chk_state, chk_state_s;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mdl = 16'hFFFF;

    always #5 clk = ~clk;

    prbs_gen_chk dut (
        .clk(clk), .rst(rst), .shift_en(shift_en), .seed_load(seed_load),
        .seed_val(seed_val), .gen_state(gen_state), .gen_bit(gen_bit),
        .chk_valid(chk_valid), .chk_bit(chk_bit), .err_clr(err_clr),
        .chk_locked(chk_locked), .err_count(err_count), .chk_state(chk_state)
    );

    prbs_gen_chk #(.ERR_W(4)) dut_s (
        .clk(clk), .rst(rst), .shift_en(shift_en), .seed_load(seed_load),
        .seed_val(seed_val), .gen_state(gen_state_s), .gen_bit(gen_bit_s),
        .chk_valid(chk_valid), .chk_bit(chk_bit), .err_clr(err_clr),
        .chk_locked(chk_locked_s), .err_count(err_count_s), .chk_state(chk_state_s)
    );

    // Reference LFSR: taps 16,15,13,4, all-zero recovers to all ones.
    function automatic logic [15:0] mdl_next(input logic [15:0] s);
        if (s == 16'h0000) return 16'hFFFF;
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rst = 1'b0; shift_en = 1'b0; seed_load = 1'b0; chk_valid = 1'b0; err_clr = 1'b0;
    endtask

    // One loopback bit: generator and checker advance together, optional inversion.
    task automatic send(input logic inv, input logic clr);
        shift_en = 1'b1; chk_valid = 1'b1; err_clr = clr;
        chk_bit = mdl[15] ^ inv;
        mdl = mdl_next(mdl);
        exp_q.push_back(mdl);
        tick;
        idle;
    endtask

    task automatic do_reset;
        idle;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        mdl = 16'hFFFF;
        exp_q.delete();
    endtask

    task automatic test_reset;
        do_reset;
        n_tests++; if (gen_state !== 16'hFFFF) begin n_fail++; $display("FAIL reset_gen: got %h exp ffff", gen_state); end
        n_tests++; if (gen_bit_s !== 1'b1 || gen_state_s !== 16'hFFFF) begin n_fail++; $display("FAIL reset_gen_s: got %h/%b exp ffff/1", gen_state_s, gen_bit_s); end
        n_tests++; if (chk_locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b exp 0", chk_locked); end
        n_tests++; if (err_count !== 16'd0 || err_count_s !== 4'd0) begin n_fail++; $display("FAIL reset_err: got %0d/%0d exp 0/0", err_count, err_count_s); end
        n_tests++; if (chk_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", chk_state); end
    endtask

    task automatic test_shift;
        logic [15:0] e;
        exp_q.push_back(16'hFFFE); exp_q.push_back(16'hFFFC);
        exp_q.push_back(16'hFFF8); exp_q.push_back(16'hFFF0);
        for (int i = 0; i < 4; i++) begin
            shift_en = 1'b1;
            tick;
            e = exp_q.pop_front();
            n_tests++; if (gen_state !== e || gen_bit !== e[15]) begin n_fail++; $display("FAIL shift_%0d: got %h exp %h", i, gen_state, e); end
        end
        idle;
        tick;
        n_tests++; if (gen_state !== 16'hFFF0) begin n_fail++; $display("FAIL shift_hold: got %h exp fff0", gen_state); end
    endtask

    task automatic test_period;
        logic [15:0] e;
        int bad, mism;
        bad = 0; mism = 0;
        do_reset;
        for (int i = 1; i <= 65535; i++) begin
            shift_en = 1'b1;
            mdl = mdl_next(mdl);
            exp_q.push_back(mdl);
            tick;
            e = exp_q.pop_front();
            if (gen_state !== e) mism++;
            if (i < 65535 && (gen_state == 16'hFFFF || gen_state == 16'h0000)) bad++;
        end
        idle;
        n_tests++; if (mism != 0) begin n_fail++; $display("FAIL period_seq: got %0d wrong states exp 0", mism); end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL period_short: got %0d early ffff/0000 exp 0", bad); end
        n_tests++; if (gen_state !== 16'hFFFF) begin n_fail++; $display("FAIL period_wrap: got %h exp ffff", gen_state); end
    endtask

    task automatic test_seed_load;
        logic [15:0] e;
        seed_load = 1'b1; seed_val = 16'h0000;
        tick; idle;
        n_tests++; if (gen_state !== 16'hFFFF) begin n_fail++; $display("FAIL seed_zero: got %h exp ffff", gen_state); end
        seed_load = 1'b1; seed_val = 16'h1234; shift_en = 1'b1;
        tick; idle;
        n_tests++; if (gen_state !== 16'h1234) begin n_fail++; $display("FAIL seed_wins: got %h exp 1234", gen_state); end
        mdl = 16'h1234;
        send(1'b0, 1'b0);
        e = exp_q.pop_front();
        n_tests++; if (gen_state !== e) begin n_fail++; $display("FAIL seed_shift: got %h exp %h", gen_state, e); end
    endtask

    task automatic test_lock;
        logic [15:0] e;
        int early, mism, unlocked;
        early = 0; mism = 0; unlocked = 0;
        do_reset;
        for (int i = 1; i <= 23; i++) begin
            send(1'b0, 1'b0);
            e = exp_q.pop_front();
            if (gen_state !== e) mism++;
            if (chk_locked !== 1'b0) early++;
        end
        n_tests++; if (early != 0) begin n_fail++; $display("FAIL lock_early: got %0d locked cycles exp 0", early); end
        send(1'b0, 1'b0);
        e = exp_q.pop_front();
        if (gen_state !== e) mism++;
        n_tests++; if (chk_locked !== 1'b1 || chk_state !== 2'd2) begin n_fail++; $display("FAIL lock_24: got %b/%0d exp 1/2", chk_locked, chk_state); end
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                send(1'b0, 1'b0);
                e = exp_q.pop_front();
                if (gen_state !== e) mism++;
            end else begin
                chk_bit = 1'($urandom_range(0, 1));
                tick;
            end
            if (chk_locked !== 1'b1) unlocked++;
        end
        n_tests++; if (unlocked != 0) begin n_fail++; $display("FAIL lock_hold: got %0d unlocked cycles exp 0", unlocked); end
        n_tests++; if (err_count !== 16'd0) begin n_fail++; $display("FAIL lock_clean_err: got %0d exp 0", err_count); end
        n_tests++; if (mism != 0) begin n_fail++; $display("FAIL lock_gen_seq: got %0d wrong states exp 0", mism); end
    endtask

    task automatic test_errors;
        int early;
        early = 0;
        send(1'b1, 1'b0);
        n_tests++; if (err_count !== 16'd1 || chk_locked !== 1'b1) begin n_fail++; $display("FAIL single_err: got %0d/%b exp 1/1", err_count, chk_locked); end
        for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send(1'b1, 1'b0);
        n_tests++; if (err_count !== 16'd4 || chk_locked !== 1'b1) begin n_fail++; $display("FAIL three_err: got %0d/%b exp 4/1", err_count, chk_locked); end
        send(1'b1, 1'b0);
        n_tests++; if (err_count !== 16'd5 || chk_locked !== 1'b0 || chk_state !== 2'd0) begin n_fail++; $display("FAIL loss: got %0d/%b/%0d exp 5/0/0", err_count, chk_locked, chk_state); end
        for (int i = 0; i < 23; i++) begin
            send(1'b0, 1'b0);
            if (chk_locked !== 1'b0) early++;
        end
        n_tests++; if (early != 0) begin n_fail++; $display("FAIL relock_early: got %0d locked cycles exp 0", early); end
        send(1'b0, 1'b0);
        n_tests++; if (chk_locked !== 1'b1 || err_count !== 16'd5) begin n_fail++; $display("FAIL relock: got %b/%0d exp 1/5", chk_locked, err_count); end
        exp_q.delete();
    endtask

    task automatic test_saturate;
        int exp_err;
        send(1'b0, 1'b1);
        n_tests++; if (err_count !== 16'd0 || err_count_s !== 4'd0 || chk_locked !== 1'b1) begin n_fail++; $display("FAIL err_clr: got %0d/%0d/%b exp 0/0/1", err_count, err_count_s, chk_locked); end
        exp_err = 0;
        for (int i = 0; i < 18; i++) begin
            send(1'b1, 1'b0);
            send(1'b0, 1'b0);
            exp_err++;
        end
        n_tests++; if (err_count_s !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d exp 15", err_count_s); end
        n_tests++; if (err_count !== 16'(exp_err)) begin n_fail++; $display("FAIL wide_count: got %0d exp %0d", err_count, exp_err); end
        send(1'b1, 1'b1);
        n_tests++; if (err_count !== 16'd1 || err_count_s !== 4'd1 || chk_locked !== 1'b1) begin n_fail++; $display("FAIL clr_plus_err: got %0d/%0d/%b exp 1/1/1", err_count, err_count_s, chk_locked); end
        exp_q.delete();
    endtask

    task automatic test_rst_mid;
        int early;
        early = 0;
        rst = 1'b1; shift_en = 1'b1; seed_load = 1'b1; seed_val = 16'h1234;
        chk_valid = 1'b1; chk_bit = ~mdl[15]; err_clr = 1'b0;
        tick;
        n_tests++; if (gen_state !== 16'hFFFF || chk_locked !== 1'b0 || err_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid: got %h/%b/%0d exp ffff/0/0", gen_state, chk_locked, err_count); end
        n_tests++; if (chk_state_s !== 2'd0 || err_count_s !== 4'd0) begin n_fail++; $display("FAIL rst_mid_s: got %0d/%0d exp 0/0", chk_state_s, err_count_s); end
        idle;
        mdl = 16'hFFFF;
        exp_q.delete();
        for (int i = 0; i < 23; i++) begin
            send(1'b0, 1'b0);
            if (chk_locked !== 1'b0) early++;
        end
        send(1'b0, 1'b0);
        n_tests++; if (early != 0 || chk_locked !== 1'b1) begin n_fail++; $display("FAIL rst_relock: got early=%0d locked=%b exp 0/1", early, chk_locked); end
        exp_q.delete();
    endtask

    initial begin
        test_reset;
        test_shift;
        test_period;
        test_seed_load;
        test_lock;
        test_errors;
        test_saturate;
        test_rst_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs_gen_chk.md
Name: prbs_gen_chk

Overview:
- Parametrised PRBS generator and checker pair; next generation of the team's fixed 16-bit LFSR.
- Generator: Fibonacci LFSR of any order with a tap-mask parameter, runtime seed load and all-zero lock-up recovery.
- Checker: receives the serial sequence, synchronises to it, reports lock and counts bit errors.
- Used in ALU/link self-test: generator drives stimulus, checker validates the returned stream.

Parameters:
- ORDER, 16, LFSR length in bits (range 3..32).
- TAP_MASK, 16'hD008, feedback taps; bit i set means state[i] is XORed into feedback. Default is taps 16,15,13,4, which is maximal length.
- SEED, all ones (ORDER bits), value loaded on reset and on lock-up recovery.
- ERR_W, 16, error counter width.
- LOCK_THRESH, 8, consecutive matches required to declare lock.
- LOSS_THRESH, 4, consecutive mismatches while locked that force loss of lock.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- shift_en  in  1  advance the generator one step.
- seed_load  in  1  load seed_val into the generator.
- seed_val  in  ORDER  runtime seed.
- gen_state  out  ORDER  generator register.
- gen_bit  out  1  serial output, gen_state[ORDER-1].
- chk_valid  in  1  chk_bit is valid this cycle.
- chk_bit  in  1  received serial bit.
- err_clr  in  1  clear err_count.
- chk_locked  out  1  checker is locked.
- err_count  out  ERR_W  saturating count of mismatches while locked.

Behaviour:
- Feedback function: fb(s) = XOR-reduce(s & TAP_MASK). Next state = {s[ORDER-2:0], fb(s)}.
- Generator priority, one update per cycle: rst > seed_load > shift_en.
  - rst: gen_state = SEED.
  - seed_load: gen_state = seed_val, or SEED if seed_val == 0.
  - shift_en with gen_state == 0: gen_state = SEED (lock-up recovery, no shift).
  - Otherwise shift.
- The generator updates on the clock edge; gen_bit is valid in the same cycle as gen_state.
- Checker holds chk_reg[ORDER-1:0], a bit counter and a match/mismatch run counter. It has three states: HUNT, VERIFY and LOCKED.
- Reset values: state HUNT, chk_reg 0, counters 0, chk_locked 0, err_count 0.
- HUNT: on each chk_valid, shift chk_bit into chk_reg[0]. After ORDER valid bits, go to VERIFY with the run counter at 0.
- VERIFY, on each chk_valid:
  - Compute pred = fb(chk_reg).
  - If chk_bit == pred: shift pred in and increment the run counter; on reaching LOCK_THRESH, go to LOCKED.
  - If mismatch: go to HUNT with the bit counter cleared. That bit counts as bit 1 of the new fill and is shifted in.
  - err_count is not incremented in VERIFY.
- LOCKED, on each chk_valid:
  - chk_reg always shifts in pred, never chk_bit. The predictor is free-running, so one channel error gives exactly one count.
  - Mismatch: err_count increments, saturating at all ones, and the mismatch run counter increments. A match clears the run counter.
  - When the run counter reaches LOSS_THRESH, go to HUNT (bit counter 0). The error on that cycle is still counted.
- chk_locked is registered: it is 1 exactly while the state is LOCKED, rising the cycle after the LOCK_THRESH-th match.
- err_clr: err_count = 0 next cycle. If a counted mismatch occurs in the same cycle, err_count = 1 (the clear applies first, then the increment). err_clr does not affect lock.
- chk_valid = 0: the checker holds all state.
- rst mid-operation: both halves return to reset values next cycle, regardless of other inputs.

Test Plan:
- Reset, then shift_en for 4 cycles with defaults: gen_state sequence FFFF -> FFFE -> FFFC -> FFF8 -> FFF0. After 65535 total shifts, gen_state == FFFF again, and no intermediate value equals FFFF or 0000.
- seed_load with seed_val = 0: gen_state = FFFF. seed_load with 1234 asserted together with shift_en: gen_state = 1234 (load wins).
- Loop gen_bit to chk_bit with chk_valid = shift_en: chk_locked rises after exactly ORDER + LOCK_THRESH = 24 valid bits; err_count stays 0 over 10000 bits.
- When locked, invert one chk_bit: err_count = 1, chk_locked stays 1. Then invert 4 consecutive bits: err_count = 5, chk_locked = 0, and the checker relocks 24 clean bits later.
- Preload err_count to all ones using ERR_W = 4: further errors hold it at 15. err_clr together with an error: err_count = 1.
- Assert rst while locked and while gen_state is mid-sequence: next cycle gen_state = FFFF, chk_locked = 0, err_count = 0.
